// File: rtl/expr_stim_driver_if.sv
// Operand/result handshake between the stimulus driver and one expression block.
// The master drives operands; the slave returns the packed 90-bit result.
interface expr_stim_driver_if;
  logic        [3:0]  a0;
  logic        [4:0]  a1;
  logic        [5:0]  a2;
  logic signed [3:0]  a3;
  logic signed [4:0]  a4;
  logic signed [5:0]  a5;
  logic        [3:0]  b0;
  logic        [4:0]  b1;
  logic        [5:0]  b2;
  logic signed [3:0]  b3;
  logic signed [4:0]  b4;
  logic signed [5:0]  b5;
  logic               op_valid;
  logic               op_ready;
  logic        [89:0] y;
  logic               y_valid;

  modport master (
    output a0, a1, a2, a3, a4, a5, b0, b1, b2, b3, b4, b5, op_valid,
    input  op_ready, y, y_valid
  );

  modport slave (
    input  a0, a1, a2, a3, a4, a5, b0, b1, b2, b3, b4, b5, op_valid,
    output op_ready, y, y_valid
  );
endinterface

// File: rtl/expr_stim_driver.sv
// LFSR operand generator and MISR result compressor wrapped around one
// expression-under-test block; a run produces one 32-bit signature.
//
// state | meaning
// IDLE  | after reset, waiting for start
// ISSUE | operands presented, waiting for op_ready
// WAIT  | operands accepted, waiting for y_valid (bounded by TIMEOUT)
// DONE  | run finished or timed out; start begins a new run
module expr_stim_driver #(
  parameter logic [59:0] SEED        = 60'h0_0000_0000_0000_001,
  parameter int          NUM_VECTORS = 256,
  parameter int          TIMEOUT     = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  expr_stim_driver_if.master  bus,
  output logic                busy,
  output logic                done,
  output logic [31:0]         signature,
  output logic [15:0]         vec_count,
  output logic                const_err,
  output logic                stray_err,
  output logic                timeout_err
);

  localparam logic [59:0] SEED_EFF = (SEED == 60'd0) ? 60'd1 : SEED;
  localparam logic [15:0] NUM_VEC  = 16'(NUM_VECTORS);
  localparam logic [15:0] TO_LOAD  = 16'(TIMEOUT - 1);
  localparam logic [31:0] POLY     = 32'h04C1_1DB7;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;

  state_t      state, state_nxt;
  logic [59:0] lfsr;
  logic [15:0] wait_cnt;
  logic        launch, handshake, capture, tmo_hit, stray;
  logic [15:0] vec_nxt;
  logic [31:0] fold;
  logic [31:0] sig_nxt;

  assign {bus.a0, bus.a1, bus.a2, bus.a3, bus.a4, bus.a5,
          bus.b0, bus.b1, bus.b2, bus.b3, bus.b4, bus.b5} = lfsr;

  assign vec_nxt = vec_count + 16'd1;
  assign fold    = bus.y[31:0] ^ bus.y[63:32] ^ {6'b0, bus.y[89:64]};
  assign sig_nxt = {signature[30:0], 1'b0} ^ (signature[31] ? POLY : 32'h0) ^ fold;
  assign stray   = bus.y_valid && (state != ST_WAIT);

  always_comb begin
    state_nxt    = state;
    launch       = 1'b0;
    handshake    = 1'b0;
    capture      = 1'b0;
    tmo_hit      = 1'b0;
    bus.op_valid = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          launch    = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        bus.op_valid = 1'b1;
        busy         = 1'b1;
        if (bus.op_ready) begin
          handshake = 1'b1;
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        busy = 1'b1;
        if (bus.y_valid) begin
          capture   = 1'b1;
          state_nxt = (vec_nxt == NUM_VEC) ? ST_DONE : ST_ISSUE;
        end else if (wait_cnt == 16'd0) begin
          tmo_hit   = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) begin
          launch    = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      lfsr        <= SEED_EFF;
      wait_cnt    <= 16'd0;
      signature   <= 32'hFFFF_FFFF;
      vec_count   <= 16'd0;
      const_err   <= 1'b0;
      stray_err   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (launch) begin
        lfsr        <= SEED_EFF;
        signature   <= 32'hFFFF_FFFF;
        vec_count   <= 16'd0;
        const_err   <= 1'b0;
        stray_err   <= 1'b0;
        timeout_err <= 1'b0;
      end
      if (handshake) begin
        lfsr     <= {lfsr[58:0], lfsr[59] ^ lfsr[58]};
        wait_cnt <= TO_LOAD;
      end
      if (capture) begin
        signature <= sig_nxt;
        vec_count <= vec_nxt;
        if ((bus.y[44:41] != 4'h7) || (bus.y[5:0] != 6'h02))
          const_err <= 1'b1;
      end else if (state == ST_WAIT && wait_cnt != 16'd0) begin
        wait_cnt <= wait_cnt - 16'd1;
      end
      if (tmo_hit)
        timeout_err <= 1'b1;
      // placed after launch so a stray result coinciding with start still sticks
      if (stray)
        stray_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_expr_stim_driver.sv
// Directed bench for expr_stim_driver: single/multi-vector runs, constant check,
// stray result, ignored start, reset mid-run, backpressure and timeout.
module tb_expr_stim_driver;
  localparam int TMO = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, const_err, stray_err, timeout_err;
  logic [31:0] signature;
  logic [15:0] vec_count;
  logic [89:0] y1, y2, y3, ybad;
  logic [31:0] sig_exp;
  int          n_vec = 0;
  int          n_bad = 0;

  expr_stim_driver_if bus ();

  expr_stim_driver #(.SEED(60'h1), .NUM_VECTORS(3), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .signature  (signature),
    .vec_count  (vec_count),
    .const_err  (const_err),
    .stray_err  (stray_err),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] misr(input logic [31:0] s, input logic [89:0] yy);
    logic [31:0] f;
    f = yy[31:0] ^ yy[63:32] ^ {6'b0, yy[89:64]};
    return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C1_1DB7 : 32'h0) ^ f;
  endfunction

  function automatic logic [59:0] ops();
    return {bus.a0, bus.a1, bus.a2, bus.a3, bus.a4, bus.a5,
            bus.b0, bus.b1, bus.b2, bus.b3, bus.b4, bus.b5};
  endfunction

  initial begin
    bus.op_ready = 1'b0;
    bus.y_valid  = 1'b0;
    bus.y        = '0;
    y1 = (90'd7 << 41) | 90'd2;
    y2 = 90'h2AB_CDEF_0123_4567_89AB_CDEF;
    y2[44:41] = 4'h7;  y2[5:0] = 6'h02;
    y3 = 90'h155_5555_AAAA_F0F0_1234_8765;
    y3[44:41] = 4'h7;  y3[5:0] = 6'h02;
    ybad = (90'd7 << 41) | 90'd3;

    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_op_valid", bus.op_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sig", signature, 32'hFFFF_FFFF);
    chk("rst_cnt", vec_count, 0);
    chk("rst_errs", {const_err, stray_err, timeout_err}, 0);
    chk("rst_ops", ops(), 60'h1);

    // stray result in IDLE
    bus.y = y1; bus.y_valid = 1'b1;
    tick();
    bus.y_valid = 1'b0;
    chk("stray_err", stray_err, 1);
    chk("stray_sig", signature, 32'hFFFF_FFFF);
    chk("stray_cnt", vec_count, 0);

    // three-vector run with op_ready tied high
    start = 1'b1; tick(); start = 1'b0;
    chk("run_op_valid", bus.op_valid, 1);
    chk("run_busy", busy, 1);
    chk("run_stray_clr", stray_err, 0);
    chk("run_b5_v1", bus.b5, 6'h01);
    chk("run_a0_v1", bus.a0, 0);
    bus.op_ready = 1'b1;
    tick();
    chk("wait_op_valid", bus.op_valid, 0);
    bus.y = y1; bus.y_valid = 1'b1;
    tick();
    bus.y_valid = 1'b0;
    chk("v1_sig", signature, 32'hFB3E_EC4B);
    chk("v1_cnt", vec_count, 1);
    chk("v2_op_valid", bus.op_valid, 1);
    chk("v2_b5", bus.b5, 6'h02);
    sig_exp = misr(32'hFB3E_EC4B, y2);
    tick();
    start = 1'b1;  // ignored while busy
    bus.y = y2; bus.y_valid = 1'b1;
    tick();
    start = 1'b0; bus.y_valid = 1'b0;
    chk("v2_cnt", vec_count, 2);
    chk("v2_sig", signature, sig_exp);
    chk("v3_b5", bus.b5, 6'h04);
    chk("v3_busy", busy, 1);
    sig_exp = misr(sig_exp, y3);
    tick();
    bus.y = y3; bus.y_valid = 1'b1;
    tick();
    bus.y_valid = 1'b0;
    chk("v3_done", done, 1);
    chk("v3_busy_low", busy, 0);
    chk("v3_cnt", vec_count, 3);
    chk("v3_sig", signature, sig_exp);
    chk("v3_errs", {const_err, stray_err, timeout_err}, 0);

    // constant-field mismatch, then reset in WAIT
    tick();
    chk("done_held", done, 1);
    start = 1'b1; tick(); start = 1'b0;
    chk("re_b5", bus.b5, 6'h01);
    chk("re_cnt", vec_count, 0);
    tick();
    bus.y = ybad; bus.y_valid = 1'b1;
    tick();
    bus.y_valid = 1'b0;
    chk("cerr_flag", const_err, 1);
    chk("cerr_sig", signature, 32'hFB3E_EC4A);
    chk("cerr_cnt", vec_count, 1);
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    bus.op_ready = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cnt", vec_count, 0);
    chk("mid_rst_sig", signature, 32'hFFFF_FFFF);
    chk("mid_rst_ops", ops(), 60'h1);
    chk("mid_rst_cerr", const_err, 0);

    // backpressure then timeout
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", bus.op_valid, 1);
      chk("bp_ops", ops(), 60'h1);
      tick();
    end
    bus.op_ready = 1'b1;
    tick();
    bus.op_ready = 1'b0;
    chk("tmo_in_wait", busy & ~bus.op_valid, 1);
    for (int i = 0; i < TMO - 1; i++) tick();
    chk("tmo_early", timeout_err, 0);
    tick();
    chk("tmo_flag", timeout_err, 1);
    chk("tmo_done", done, 1);
    chk("tmo_cnt", vec_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/expr_stim_driver.md
# expr_stim_driver

Operand-side driver and result-side checker for the expression-under-test blocks in the vloghammer regression. It generates pseudo-random operand bundles a0..a5/b0..b5, presents them over a valid/ready handshake, then captures the packed 90-bit result `y`. Each result is compressed into a 32-bit MISR signature, and the two constant result fields are checked. It closes the loop around one expression block so a run yields a single comparable signature.

## Interface
- SEED, 60'h0_0000_0000_0000_001: initial LFSR state; a value of 0 is replaced by 1.
- NUM_VECTORS, 256: vectors per run, range 1..65535.
- TIMEOUT, 64: maximum cycles spent in WAIT for `y_valid`.
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- start  in  1  begins a run from IDLE or DONE; ignored while busy.
- a0 out 4, a1 out 5, a2 out 6, a3 out 4 signed, a4 out 5 signed, a5 out 6 signed: operands A.
- b0 out 4, b1 out 5, b2 out 6, b3 out 4 signed, b4 out 5 signed, b5 out 6 signed: operands B.
- op_valid  out  1  operands valid.
- op_ready  in  1  DUT accepts operands.
- y  in  90  packed result {y0..y17}.
- y_valid  in  1  `y` corresponds to the last accepted operands.
- busy  out  1  run in progress.
- done  out  1  run finished; held high until the next start or reset.
- signature  out  32  MISR value.
- vec_count  out  16  number of results captured.
- const_err  out  1  sticky; a constant field mismatched.
- stray_err  out  1  sticky; `y_valid` arrived outside WAIT.
- timeout_err  out  1  sticky; WAIT exceeded TIMEOUT.

## Operation
- State machine: IDLE, ISSUE, WAIT, DONE.
- **IDLE / DONE, on start:**
  - Load lfsr=SEED (or 1 if SEED is 0), vec_count=0, signature=32'hFFFF_FFFF.
  - Clear all error flags and done.
  - Go to ISSUE.
- **Operand mapping:** {a0,a1,a2,a3,a4,a5,b0,b1,b2,b3,b4,b5} = lfsr[59:0], MSB-first in that order (a0=lfsr[59:56], ..., b5=lfsr[5:0]). Operands are driven straight from the lfsr register and are stable whenever op_valid=1.
- **ISSUE:**
  - op_valid=1.
  - When op_ready=1: advance the LFSR, clear the wait counter, go to WAIT.
  - LFSR step (Fibonacci, x^60+x^59+1): lfsr <= {lfsr[58:0], lfsr[59]^lfsr[58]}.
- **WAIT:**
  - op_valid=0.
  - When y_valid=1:
    - signature <= {sig[30:0],1'b0} ^ (sig[31] ? 32'h04C1_1DB7 : 0) ^ fold.
    - fold = y[31:0] ^ y[63:32] ^ {6'b0, y[89:64]}.
    - const_err |= (y[44:41] != 4'h7) || (y[5:0] != 6'h02). These are fields y9 and y17.
    - vec_count += 1.
    - If the new vec_count == NUM_VECTORS go to DONE, else go to ISSUE.
  - If the wait counter reaches TIMEOUT without y_valid: set timeout_err, go to DONE.
- **Stray results:** y_valid in IDLE, ISSUE or DONE sets stray_err; the signature and count are unchanged.
- **start while busy** has no effect.
- **Outputs:** busy=1 in ISSUE and WAIT; done=1 in DONE only.
- **Reset values:**
  - State IDLE.
  - op_valid=0, busy=0, done=0.
  - lfsr=SEED (or 1), so the operands show SEED.
  - signature=32'hFFFF_FFFF, vec_count=0.
  - All error flags 0.
- **Reset mid-run** aborts to IDLE with the reset values above; no partial signature is retained.

## Timing
- start sampled at edge t: op_valid=1 during cycle t+1.
- With op_ready tied to 1:
  - ISSUE lasts one cycle.
  - y_valid may be asserted as early as the cycle after the handshake.
  - The minimum per-vector period is 2 cycles.
- signature, vec_count and const_err update at the edge that samples y_valid.
- done rises at the same edge as the final capture.
- The timeout fires on the TIMEOUT-th WAIT cycle without y_valid.
- After DONE, a start at edge t re-enters ISSUE at t+1.

## Test plan
- **Single vector:** SEED=1, NUM_VECTORS=1, op_ready=1, y = (7<<41)|2 one cycle after the handshake.
  - Operands: b5=6'h01, all others 0.
  - Result: signature=32'hFB3E_EC4B, vec_count=1, done=1, no errors.
- **LFSR stepping:** SEED=1, NUM_VECTORS=3.
  - The second vector presents b5=6'h02.
  - The third vector presents b5=6'h04.
  - done after exactly 3 captures.
- **Constant check:** the same single-vector run with y[5:0]=6'h03 -> const_err=1; the signature still updates.
- **Backpressure and timeout:**
  - Hold op_ready=0 for 10 cycles: operands stay stable, op_valid stays 1.
  - Then accept, and never assert y_valid: timeout_err=1 exactly TIMEOUT cycles later, state DONE.
- **Stray result and ignored start:**
  - y_valid in IDLE -> stray_err=1, signature stays 32'hFFFF_FFFF.
  - start pulsed during WAIT is ignored.
- **Reset mid-run:** assert rst in WAIT after 5 captures -> next cycle IDLE, vec_count=0, signature=32'hFFFF_FFFF, operands=SEED.
